// File: rtl/spi_xfer_ctrl.sv
// Transaction sequencer feeding spi_master: command in, TX FIFO to byte starts, RX bytes out, chip select.
// Optional byte watchdog enabled by defining SPI_XFER_TIMEOUT_EN.
module spi_xfer_ctrl #(
    parameter int LEN_W        = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int CS_SETUP_CYC = 2,
    parameter int CS_HOLD_CYC  = 2,
    parameter int GAP_CYC      = 2,
    parameter int TIMEOUT_CYC  = 1024
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [LEN_W-1:0] i_cmd_len,
    input  logic             i_cmd_mlb,
    input  logic [1:0]       i_cmd_cdiv,
    input  logic             i_tx_valid,
    output logic             o_tx_ready,
    input  logic [7:0]       i_tx_data,
    output logic             o_rx_valid,
    input  logic             i_rx_ready,
    output logic [7:0]       o_rx_data,
    output logic             o_busy,
    output logic             o_err,
    output logic             o_ss_n,
    output logic             o_m_start,
    output logic [7:0]       o_m_tdat,
    output logic             o_m_mlb,
    output logic [1:0]       o_m_cdiv,
    input  logic             i_m_done,
    input  logic [7:0]       i_m_rdata
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int SEQ_MAX = (CS_SETUP_CYC > CS_HOLD_CYC) ? CS_SETUP_CYC : CS_HOLD_CYC;
    localparam int GAP_MAX = (SEQ_MAX > GAP_CYC) ? SEQ_MAX : GAP_CYC;
    localparam int CNT_MAX = (GAP_MAX > TIMEOUT_CYC) ? GAP_MAX : TIMEOUT_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CS_SETUP,
        S_LOAD,
        S_WAIT_DONE,
        S_GAP,
        S_CS_HOLD
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [LEN_W:0]     r_byte_idx;
    logic [LEN_W-1:0]   r_len;
    logic               r_done_q;
    logic [7:0]         r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_count;
    logic               r_ss_n;
    logic               r_m_start;
    logic [7:0]         r_m_tdat;
    logic               r_m_mlb;
    logic [1:0]         r_m_cdiv;
    logic               r_rx_valid;
    logic [7:0]         r_rx_data;

    logic w_done_rise;
    logic w_push;
    logic w_pop;
    logic w_last;
    logic w_cmd_accept;
`ifdef SPI_XFER_TIMEOUT_EN
    logic w_timeout;
    logic r_err;
`endif

    assign w_done_rise  = i_m_done & ~r_done_q;
    assign w_push       = i_tx_valid & o_tx_ready;
    assign w_last       = (r_byte_idx == {1'b0, r_len});
    assign w_cmd_accept = (r_state == S_IDLE) & i_cmd_valid;

    assign o_cmd_ready = (r_state == S_IDLE) & ~i_rst;
    assign o_tx_ready  = (r_count != (PTR_W+1)'(FIFO_DEPTH));
    assign o_busy      = (r_state != S_IDLE);
    assign o_ss_n      = r_ss_n;
    assign o_m_start   = r_m_start;
    assign o_m_tdat    = r_m_tdat;
    assign o_m_mlb     = r_m_mlb;
    assign o_m_cdiv    = r_m_cdiv;
    assign o_rx_valid  = r_rx_valid;
    assign o_rx_data   = r_rx_data;

    // A byte is launched only when data is available and the previous RX byte has been taken.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
`ifdef SPI_XFER_TIMEOUT_EN
        w_timeout    = 1'b0;
`endif
        case (r_state)
            S_IDLE:      if (i_cmd_valid) w_state_next = S_CS_SETUP;
            S_CS_SETUP:  if (r_cnt == CNT_W'(CS_SETUP_CYC - 1)) w_state_next = S_LOAD;
            S_LOAD: begin
                if ((r_count != '0) && !r_rx_valid) begin
                    w_pop        = 1'b1;
                    w_state_next = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (w_done_rise) begin
                    w_state_next = w_last ? S_CS_HOLD : S_GAP;
                end
`ifdef SPI_XFER_TIMEOUT_EN
                else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    w_timeout    = 1'b1;
                    w_state_next = S_CS_HOLD;
                end
`endif
            end
            S_GAP:       if (r_cnt == CNT_W'(GAP_CYC - 1)) w_state_next = S_LOAD;
            S_CS_HOLD:   if (r_cnt == CNT_W'(CS_HOLD_CYC - 1)) w_state_next = S_IDLE;
            default:     w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_byte_idx <= '0;
            r_len      <= '0;
            r_done_q   <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_ss_n     <= 1'b1;
            r_m_start  <= 1'b0;
            r_m_tdat   <= '0;
            r_m_mlb    <= 1'b0;
            r_m_cdiv   <= '0;
            r_rx_valid <= 1'b0;
            r_rx_data  <= '0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= (w_state_next != r_state) ? '0 : r_cnt + CNT_W'(1);
            r_done_q  <= i_m_done;
            r_m_start <= w_pop;
            r_ss_n    <= (w_state_next == S_IDLE);

            if (w_cmd_accept) begin
                r_len      <= i_cmd_len;
                r_m_mlb    <= i_cmd_mlb;
                r_m_cdiv   <= i_cmd_cdiv;
                r_byte_idx <= '0;
            end

            if (w_pop) r_m_tdat <= r_fifo[r_rd_ptr];

            if ((r_state == S_WAIT_DONE) && w_done_rise) begin
                r_rx_data  <= i_m_rdata;
                r_rx_valid <= 1'b1;
                r_byte_idx <= r_byte_idx + (LEN_W+1)'(1);
            end else if (r_rx_valid && i_rx_ready) begin
                r_rx_valid <= 1'b0;
            end

            // A watchdog flush discards stale bytes but keeps a push landing in the same cycle.
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_push);
`ifdef SPI_XFER_TIMEOUT_EN
            if (w_timeout) begin
                r_rd_ptr <= r_wr_ptr;
                r_count  <= (PTR_W+1)'(w_push);
            end else
`endif
            begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop);
                r_count  <= r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= i_tx_data;
    end

`ifdef SPI_XFER_TIMEOUT_EN
    always_ff @(posedge i_clk) begin
        if (i_rst)             r_err <= 1'b0;
        else if (w_cmd_accept) r_err <= 1'b0;
        else if (w_timeout)    r_err <= 1'b1;
    end
    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Self-checking bench for spi_xfer_ctrl with a reactive spi_master stand-in and a byte-queue reference.
module tb_spi_xfer_ctrl;

    localparam int LEN_W        = 8;
    localparam int FIFO_DEPTH   = 4;
    localparam int CS_SETUP_CYC = 2;
    localparam int CS_HOLD_CYC  = 2;
    localparam int GAP_CYC      = 2;
    localparam int TIMEOUT_CYC  = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             i_rst = 1'b1;
    logic             i_cmd_valid = 1'b0;
    logic             o_cmd_ready;
    logic [LEN_W-1:0] i_cmd_len = '0;
    logic             i_cmd_mlb = 1'b0;
    logic [1:0]       i_cmd_cdiv = '0;
    logic             i_tx_valid = 1'b0;
    logic             o_tx_ready;
    logic [7:0]       i_tx_data = '0;
    logic             o_rx_valid;
    logic             i_rx_ready = 1'b0;
    logic [7:0]       o_rx_data;
    logic             o_busy;
    logic             o_err;
    logic             o_ss_n;
    logic             o_m_start;
    logic [7:0]       o_m_tdat;
    logic             o_m_mlb;
    logic [1:0]       o_m_cdiv;
    logic             i_m_done = 1'b0;
    logic [7:0]       i_m_rdata = '0;

    spi_xfer_ctrl #(
        .LEN_W(LEN_W), .FIFO_DEPTH(FIFO_DEPTH), .CS_SETUP_CYC(CS_SETUP_CYC),
        .CS_HOLD_CYC(CS_HOLD_CYC), .GAP_CYC(GAP_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .i_clk(clk), .i_rst(i_rst),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_len(i_cmd_len),
        .i_cmd_mlb(i_cmd_mlb), .i_cmd_cdiv(i_cmd_cdiv),
        .i_tx_valid(i_tx_valid), .o_tx_ready(o_tx_ready), .i_tx_data(i_tx_data),
        .o_rx_valid(o_rx_valid), .i_rx_ready(i_rx_ready), .o_rx_data(o_rx_data),
        .o_busy(o_busy), .o_err(o_err), .o_ss_n(o_ss_n),
        .o_m_start(o_m_start), .o_m_tdat(o_m_tdat), .o_m_mlb(o_m_mlb), .o_m_cdiv(o_m_cdiv),
        .i_m_done(i_m_done), .i_m_rdata(i_m_rdata)
    );

    int nChecks = 0;
    int nPass   = 0;

    // Reference: bytes expected back on RX, in push order, already transformed by the slave.
    logic [7:0] expQ [$];
    bit         expMlb = 1'b0;
    logic [1:0] expCdiv = '0;
    logic [7:0] mask = 8'h00;
    int         latMin = 1;
    int         latMax = 12;
    bit         slvHang = 1'b0;

    int         cyc = 0;
    int         startCount = 0;
    int         violCount = 0;
    bit         slvActive = 1'b0;
    logic [7:0] slvT = '0;
    int         slvCnt = 0;
    int         doneCyc = -1000;
    int         ssFallCyc = 0;
    bit         firstPending = 1'b0;
    logic       prevSs = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // spi_master stand-in plus protocol watcher; everything sampled on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (i_rst) begin
            slvActive    = 1'b0;
            i_m_done     = 1'b0;
            firstPending = 1'b0;
        end else begin
            if (prevSs && !o_ss_n) begin
                ssFallCyc    = cyc;
                firstPending = 1'b1;
            end
            if (!prevSs && o_ss_n && (cyc - doneCyc) < CS_HOLD_CYC) violCount++;
            if (o_m_start) begin
                startCount++;
                if (o_ss_n || o_rx_valid || slvActive) violCount++;
                if (o_m_mlb !== expMlb || o_m_cdiv !== expCdiv) violCount++;
                if (firstPending) begin
                    if ((cyc - ssFallCyc) < CS_SETUP_CYC) violCount++;
                    firstPending = 1'b0;
                end else if ((cyc - doneCyc - 1) < GAP_CYC) begin
                    violCount++;
                end
                slvActive = 1'b1;
                slvT      = o_m_tdat;
                i_m_done  = 1'b0;
                slvCnt    = $urandom_range(latMin, latMax);
            end else if (slvActive) begin
                if (o_m_tdat !== slvT || o_ss_n) violCount++;
                if (slvCnt > 0) slvCnt--;
                else if (!slvHang) begin
                    i_m_done  = 1'b1;
                    i_m_rdata = slvT ^ mask;
                    slvActive = 1'b0;
                    doneCyc   = cyc;
                end
            end
        end
        prevSs = o_ss_n;
    end

    task automatic applyStimulus(input int len, input bit mlb, input logic [1:0] cdiv);
        @(negedge clk);
        expMlb      = mlb;
        expCdiv     = cdiv;
        i_cmd_len   = LEN_W'(len);
        i_cmd_mlb   = mlb;
        i_cmd_cdiv  = cdiv;
        i_cmd_valid = 1'b1;
        for (int n = 0; n < 20000 && !o_cmd_ready; n++) @(negedge clk);
        check("cmd_accept", o_cmd_ready, 1);
        @(negedge clk);
        i_cmd_valid = 1'b0;
    endtask

    task automatic pushByte(input logic [7:0] b);
        @(negedge clk);
        i_tx_data  = b;
        i_tx_valid = 1'b1;
        for (int n = 0; n < 20000 && !o_tx_ready; n++) @(negedge clk);
        check("tx_push", o_tx_ready, 1);
        @(negedge clk);
        i_tx_valid = 1'b0;
    endtask

    task automatic consume(input int n, input int readyPct);
        int got = 0;
        for (int c = 0; c < 30000 && got < n; c++) begin
            @(negedge clk);
            i_rx_ready = ($urandom_range(1, 100) <= readyPct);
            if (o_rx_valid && i_rx_ready) begin
                check("rx_byte", o_rx_data, (expQ.size() > 0) ? expQ.pop_front() : 8'hxx);
                got++;
            end
        end
        check("rx_count", got, n);
        @(negedge clk);
        i_rx_ready = 1'b0;
    endtask

    task automatic checkOutput(input int expStarts, input int base, input int violBase,
                               input bit eMlb, input logic [1:0] eCdiv);
        for (int n = 0; n < 20000 && o_busy; n++) @(negedge clk);
        check("idle_busy", o_busy, 0);
        check("idle_ss_n", o_ss_n, 1);
        check("start_count", startCount - base, expStarts);
        check("protocol_viol", violCount - violBase, 0);
        check("m_mlb", o_m_mlb, eMlb);
        check("m_cdiv", o_m_cdiv, eCdiv);
        check("rx_valid_idle", o_rx_valid, 0);
    endtask

    typedef struct {
        int          len;
        bit          mlb;
        logic [1:0]  cdiv;
        bit          preload;
        logic [31:0] data;
        logic [7:0]  vmask;
        int          readyPct;
        int          expStarts;
        bit          expMlb;
        logic [1:0]  expCdiv;
    } vec_t;

    task automatic runVec(input vec_t v);
        logic [7:0] d [$];
        logic [31:0] fixedData;
        int base = startCount;
        int violBase = violCount;
        fixedData = v.data;
        for (int i = 0; i <= v.len; i++) begin
            if (v.preload && i < 4) d.push_back(fixedData[31 - 8*i -: 8]);
            else d.push_back(8'($urandom_range(0, 255)));
        end
        mask = v.vmask;
        expQ.delete();
        foreach (d[i]) expQ.push_back(d[i] ^ v.vmask);
        if (v.preload) begin
            foreach (d[i]) pushByte(d[i]);
            fork
                applyStimulus(v.len, v.mlb, v.cdiv);
                consume(v.len + 1, v.readyPct);
            join
        end else begin
            fork
                applyStimulus(v.len, v.mlb, v.cdiv);
                begin foreach (d[i]) pushByte(d[i]); end
                consume(v.len + 1, v.readyPct);
            join
        end
        checkOutput(v.expStarts, base, violBase, v.expMlb, v.expCdiv);
        check("err_clear", o_err, 0);
    endtask

    vec_t vecs [5];

    initial begin
        int base;
        int violBase;
        vec_t rv;

        vecs[0] = '{len:0,   mlb:1'b1, cdiv:2'd0, preload:1'b1, data:32'hA5000000, vmask:8'h00,
                    readyPct:100, expStarts:1,   expMlb:1'b1, expCdiv:2'd0};
        vecs[1] = '{len:3,   mlb:1'b0, cdiv:2'd2, preload:1'b1, data:32'h11223344, vmask:8'h00,
                    readyPct:100, expStarts:4,   expMlb:1'b0, expCdiv:2'd2};
        vecs[2] = '{len:7,   mlb:1'b1, cdiv:2'd3, preload:1'b0, data:32'h0,        vmask:8'h3C,
                    readyPct:50,  expStarts:8,   expMlb:1'b1, expCdiv:2'd3};
        vecs[3] = '{len:255, mlb:1'b0, cdiv:2'd1, preload:1'b0, data:32'h0,        vmask:8'hC3,
                    readyPct:80,  expStarts:256, expMlb:1'b0, expCdiv:2'd1};
        vecs[4] = '{len:1,   mlb:1'b1, cdiv:2'd2, preload:1'b0, data:32'h0,        vmask:8'hFF,
                    readyPct:30,  expStarts:2,   expMlb:1'b1, expCdiv:2'd2};

        repeat (2) @(negedge clk);
        check("rst_cmd_ready", o_cmd_ready, 0);
        check("rst_ss_n", o_ss_n, 1);
        check("rst_busy", o_busy, 0);
        check("rst_m_start", o_m_start, 0);
        check("rst_m_tdat", o_m_tdat, 0);
        check("rst_m_mlb", o_m_mlb, 0);
        check("rst_m_cdiv", o_m_cdiv, 0);
        check("rst_rx_valid", o_rx_valid, 0);
        check("rst_rx_data", o_rx_data, 0);
        check("rst_err", o_err, 0);
        check("rst_tx_ready", o_tx_ready, 1);
        i_rst = 1'b0;
        @(negedge clk);
        check("post_rst_cmd_ready", o_cmd_ready, 1);

        $display("[TB] table vectors");
        for (int i = 0; i < 5; i++) runVec(vecs[i]);

        $display("[TB] random commands");
        for (int i = 0; i < 6; i++) begin
            rv.len       = $urandom_range(0, 20);
            rv.mlb       = 1'($urandom_range(0, 1));
            rv.cdiv      = 2'($urandom_range(0, 3));
            rv.preload   = 1'b0;
            rv.data      = 32'h0;
            rv.vmask     = 8'($urandom_range(0, 255));
            rv.readyPct  = $urandom_range(20, 100);
            rv.expStarts = rv.len + 1;
            rv.expMlb    = rv.mlb;
            rv.expCdiv   = rv.cdiv;
            runVec(rv);
        end

        $display("[TB] rx backpressure");
        mask = 8'h5A;
        expQ.delete();
        base = startCount;
        violBase = violCount;
        for (int i = 0; i < 3; i++) begin
            pushByte(8'(8'h70 + i));
            expQ.push_back(8'(8'h70 + i) ^ 8'h5A);
        end
        applyStimulus(2, 1'b0, 2'd3);
        for (int n = 0; n < 300 && !o_rx_valid; n++) @(negedge clk);
        check("stall_first_valid", o_rx_valid, 1);
        repeat (500) @(negedge clk);
        check("stall_starts", startCount - base, 1);
        check("stall_rx_valid", o_rx_valid, 1);
        check("stall_rx_data", o_rx_data, expQ[0]);
        consume(3, 100);
        checkOutput(3, base, violBase, 1'b0, 2'd3);

        $display("[TB] fifo full");
        mask = 8'h00;
        expQ.delete();
        base = startCount;
        violBase = violCount;
        for (int i = 0; i < 4; i++) begin
            pushByte(8'(8'hB0 + i));
            expQ.push_back(8'(8'hB0 + i));
        end
        check("fifo_full_ready", o_tx_ready, 0);
        repeat (10) @(negedge clk);
        check("fifo_full_hold", o_tx_ready, 0);
        expQ.push_back(8'hB4);
        fork
            applyStimulus(4, 1'b1, 2'd1);
            begin
                pushByte(8'hB4);
                check("fifo_5th_after_pop", startCount > base, 1);
            end
            consume(5, 100);
        join
        checkOutput(5, base, violBase, 1'b1, 2'd1);

        $display("[TB] reset mid-transaction");
        latMin = 30;
        latMax = 30;
        i_rx_ready = 1'b1;
        base = startCount;
        for (int i = 0; i < 4; i++) pushByte(8'(8'hD0 + i));
        applyStimulus(3, 1'b0, 2'd2);
        for (int n = 0; n < 500 && (startCount - base) < 2; n++) @(negedge clk);
        check("rst_reach_byte2", startCount - base, 2);
        @(negedge clk);
        i_rst = 1'b1;
        @(negedge clk);
        check("abort_ss_n", o_ss_n, 1);
        check("abort_busy", o_busy, 0);
        check("abort_rx_valid", o_rx_valid, 0);
        check("abort_m_start", o_m_start, 0);
        check("abort_cmd_ready_in_rst", o_cmd_ready, 0);
        i_rst = 1'b0;
        i_rx_ready = 1'b0;
        @(negedge clk);
        check("abort_cmd_ready", o_cmd_ready, 1);
        latMin = 1;
        latMax = 12;
        base = startCount;
        violBase = violCount;
        applyStimulus(0, 1'b1, 2'd3);
        repeat (40) @(negedge clk);
        check("starve_no_start", startCount - base, 0);
        check("starve_ss_n", o_ss_n, 0);
        check("starve_busy", o_busy, 1);
        mask = 8'h81;
        expQ.delete();
        expQ.push_back(8'h42 ^ 8'h81);
        pushByte(8'h42);
        consume(1, 100);
        checkOutput(1, base, violBase, 1'b1, 2'd3);

        $display("[TB] stuck spi_master");
        slvHang = 1'b1;
        base = startCount;
        pushByte(8'h99);
        applyStimulus(0, 1'b0, 2'd0);
`ifdef SPI_XFER_TIMEOUT_EN
        for (int n = 0; n < TIMEOUT_CYC + 200 && !o_err; n++) @(negedge clk);
        check("timeout_err", o_err, 1);
        for (int n = 0; n < 100 && o_busy; n++) @(negedge clk);
        check("timeout_ss_n", o_ss_n, 1);
        check("timeout_busy", o_busy, 0);
        check("timeout_no_rx", o_rx_valid, 0);
        slvHang = 1'b0;
        repeat (4) @(negedge clk);
        runVec(vecs[0]);
`else
        repeat (200) @(negedge clk);
        check("hang_busy", o_busy, 1);
        check("hang_ss_n", o_ss_n, 0);
        check("hang_starts", startCount - base, 1);
        check("hang_err", o_err, 0);
        @(negedge clk);
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        slvHang = 1'b0;
        @(negedge clk);
        check("hang_recover_idle", o_busy, 0);
        runVec(vecs[0]);
`endif

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not complete, checks %0d/%0d", nPass, nChecks);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
